serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor.sv | 107 ++++++++++
 tb/tb_serial_subtractor.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: a single full-subtractor cell walks the operands LSB first,
// one bit per clock, and presents diff/borrow/ovf together with a one-cycle done.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for start
  // RUN   | one operand bit processed per clock
  // DONE  | result valid, done pulse; start here chains straight into RUN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b, res;
  logic [CW-1:0]    cnt;
  logic             bflop;
  logic             msb_a, msb_b;
  logic             d_bit, b_out;
  logic             last_bit;
  logic             accept;

  assign d_bit    = sh_a[0] ^ sh_b[0] ^ bflop;
  assign b_out    = (~sh_a[0] & sh_b[0]) | (~sh_a[0] & bflop) | (sh_b[0] & bflop);
  assign last_bit = (cnt == CW'(WIDTH - 1));
  assign accept   = start && ((state == IDLE) || (state == DONE));

  always_comb begin
    state_nxt = IDLE;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: state_nxt = start ? RUN : IDLE;
      RUN: begin
        busy      = 1'b1;
        state_nxt = last_bit ? DONE : RUN;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Outputs are loaded on the edge that enters DONE so they are already valid
  // while done is high, and then hold until the next completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a   <= '0;
      sh_b   <= '0;
      res    <= '0;
      cnt    <= '0;
      bflop  <= 1'b0;
      msb_a  <= 1'b0;
      msb_b  <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      ovf    <= 1'b0;
    end else if (accept) begin
      sh_a  <= a;
      sh_b  <= b;
      msb_a <= a[WIDTH-1];
      msb_b <= b[WIDTH-1];
      cnt   <= '0;
      bflop <= 1'b0;
    end else if (state == RUN) begin
      sh_a  <= {1'b0, sh_a[WIDTH-1:1]};
      sh_b  <= {1'b0, sh_b[WIDTH-1:1]};
      res   <= {d_bit, res[WIDTH-1:1]};
      bflop <= b_out;
      if (last_bit) begin
        diff   <= {d_bit, res[WIDTH-1:1]};
        borrow <= b_out;
        ovf    <= (msb_a ^ msb_b) & (msb_a ^ d_bit);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed bench for serial_subtractor at WIDTH=8 and WIDTH=16,
// checked against an integer-arithmetic model of a-b.
module tb_serial_subtractor;

  logic        clk;
  logic        rst_n;
  logic        s8, s16;
  logic [7:0]  a8, b8, diff8;
  logic [15:0] a16, b16, diff16;
  logic        busy8, done8, bor8, ovf8;
  logic        busy16, done16, bor16, ovf16;

  int nchk = 0;
  int nerr = 0;

  logic [31:0] pd[2];
  logic        pb[2];
  logic        po[2];

  serial_subtractor #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .start(s8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .diff(diff8), .borrow(bor8), .ovf(ovf8)
  );

  serial_subtractor #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start(s16), .a(a16), .b(b16),
    .busy(busy16), .done(done16), .diff(diff16), .borrow(bor16), .ovf(ovf16)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction with signed range test for overflow.
  task automatic ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                           output logic [31:0] ed, output logic eb, output logic eo);
    longint m, sa, sb, r;
    m  = (longint'(1) << w);
    ed = 32'((longint'(av) - longint'(bv)) % m + m) % m;
    ed = 32'((longint'(av) - longint'(bv) + m) % m);
    eb = (av < bv);
    sa = (av >= 32'(m / 2)) ? longint'(av) - m : longint'(av);
    sb = (bv >= 32'(m / 2)) ? longint'(bv) - m : longint'(bv);
    r  = sa - sb;
    eo = (r > (m / 2) - 1) || (r < -(m / 2));
  endtask

  function automatic logic [31:0] g_diff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff16);
  endfunction
  function automatic logic g_done(input int w);
    return (w == 8) ? done8 : done16;
  endfunction
  function automatic logic g_busy(input int w);
    return (w == 8) ? busy8 : busy16;
  endfunction
  function automatic logic g_bor(input int w);
    return (w == 8) ? bor8 : bor16;
  endfunction
  function automatic logic g_ovf(input int w);
    return (w == 8) ? ovf8 : ovf16;
  endfunction

  task automatic drv(input int w, input logic st, input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      s8 = st; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      s16 = st; a16 = av[15:0]; b16 = bv[15:0];
    end
  endtask

  task automatic set_start(input int w, input logic st);
    if (w == 8) s8 = st;
    else s16 = st;
  endtask

  // Called at a negedge with the DUT idle. scramble: change operands after
  // capture and pulse start mid-run; both must be ignored.
  task automatic run_op(input int w, input logic [31:0] av, input logic [31:0] bv, input bit scramble);
    logic [31:0] ed;
    logic        eb, eo;
    int          cyc;
    int          sel;
    sel = (w == 16) ? 1 : 0;
    ref_model(w, av, bv, ed, eb, eo);
    drv(w, 1'b1, av, bv);
    @(negedge clk);
    set_start(w, 1'b0);
    if (scramble) drv(w, 1'b0, $urandom, $urandom);
    cyc = 1;
    while (!g_done(w) && cyc < 64) begin
      chk("busy_run", 32'(g_busy(w)), 32'd1);
      chk("hold_diff", g_diff(w), pd[sel]);
      chk("hold_borrow", 32'(g_bor(w)), 32'(pb[sel]));
      if (scramble && cyc == 3) set_start(w, 1'b1);
      if (scramble && cyc == 4) set_start(w, 1'b0);
      @(negedge clk);
      cyc++;
    end
    chk("latency", 32'(cyc), 32'(w + 1));
    chk("diff", g_diff(w), ed);
    chk("borrow", 32'(g_bor(w)), 32'(eb));
    chk("ovf", 32'(g_ovf(w)), 32'(eo));
    pd[sel] = ed;
    pb[sel] = eb;
    po[sel] = eo;
    @(negedge clk);
    chk("done_pulse", 32'(g_done(w)), 32'd0);
    chk("idle_busy", 32'(g_busy(w)), 32'd0);
    chk("hold_after", g_diff(w), ed);
  endtask

  initial begin
    logic [31:0] qa[$];
    logic [31:0] qb[$];
    logic [31:0] ed, av, bv, ca, cb;
    logic        eb, eo;

    rst_n = 1'b0;
    drv(8, 1'b0, 0, 0);
    drv(16, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      pd[i] = '0; pb[i] = 1'b0; po[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_diff", 32'(diff8), 32'd0);
    chk("rst_borrow", 32'(bor8), 32'd0);
    chk("rst_ovf", 32'(ovf8), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(8, 32'h5A, 32'h23, 1'b0);
    run_op(8, 32'h10, 32'h20, 1'b0);
    run_op(8, 32'h80, 32'h01, 1'b1);
    run_op(8, 32'h00, 32'h00, 1'b0);
    run_op(8, 32'hFF, 32'hFF, 1'b0);
    run_op(8, 32'h00, 32'hFF, 1'b1);
    run_op(8, 32'h7F, 32'h80, 1'b0);
    run_op(16, 32'h0000, 32'h0001, 1'b0);
    run_op(16, 32'h8000, 32'h0001, 1'b1);
    run_op(16, 32'h7FFF, 32'hFFFF, 1'b0);

    // Start held high with operands changing every cycle: one result per 9 cycles.
    for (int k = 0; k <= 45; k++) begin
      chk("b2b_done", 32'(done8), 32'((k > 0) && (k % 9 == 0)));
      if (done8) begin
        if (qa.size() == 0) begin
          chk("b2b_queue", 32'd0, 32'd1);
        end else begin
          ca = qa.pop_front();
          cb = qb.pop_front();
          ref_model(8, ca, cb, ed, eb, eo);
          chk("b2b_diff", 32'(diff8), ed);
          chk("b2b_borrow", 32'(bor8), 32'(eb));
          chk("b2b_ovf", 32'(ovf8), 32'(eo));
          pd[0] = ed; pb[0] = eb; po[0] = eo;
        end
      end
      if (k < 45) begin
        av = $urandom & 32'hFF;
        bv = $urandom & 32'hFF;
        drv(8, 1'b1, av, bv);
        if (k % 9 == 0) begin
          qa.push_back(av);
          qb.push_back(bv);
        end
        @(negedge clk);
      end else begin
        drv(8, 1'b0, 0, 0);
      end
    end
    chk("b2b_left", 32'(qa.size()), 32'd0);
    @(negedge clk);

    // Reset in the middle of an operation.
    drv(8, 1'b1, 32'h5A, 32'h23);
    @(negedge clk);
    set_start(8, 1'b0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_done", 32'(done8), 32'd0);
    chk("abort_diff", 32'(diff8), 32'd0);
    chk("abort_borrow", 32'(bor8), 32'd0);
    chk("abort_ovf", 32'(ovf8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pd[i] = '0; pb[i] = 1'b0; po[i] = 1'b0;
    end
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", 32'(done8), 32'd0);
      @(negedge clk);
    end
    run_op(8, 32'h03, 32'h01, 1'b0);

    for (int k = 0; k < 1000; k++)
      run_op(8, $urandom & 32'hFF, $urandom & 32'hFF, bit'(k % 2));
    for (int k = 0; k < 1000; k++)
      run_op(16, $urandom & 32'hFFFF, $urandom & 32'hFFFF, bit'(k % 2));

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
